// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the RV32I writeback stage:
//   - load funct3 encodings (LB, LH, LW, LBU, LHU)
//   - wb_state_t, the writeback FSM state type (WB_RUN, WB_WAIT)
//   - load_extract(), which aligns and extends a raw data-memory word
// Imported by writeback_stage and writeback_regfile.
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic {
      WB_RUN  = 1'b0,
      WB_WAIT = 1'b1
   } wb_state_t;

   // Select the addressed byte/half from an aligned word and extend it to 32 bits.
   // For halfword loads only offset[1] matters; offset[0] is ignored.
   // Reserved encodings (011, 110, 111) produce zero.
   function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] word);
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      logic [31:0]        res;
      byte_s = word[{offset, 3'b000} +: 8];
      half_s = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         LB:      res = {{24{byte_s[7]}}, byte_s};
         LBU:     res = {24'h000000, byte_s};
         LH:      res = {{16{half_s[15]}}, half_s};
         LHU:     res = {16'h0000, half_s};
         LW:      res = word;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
// RV32I integer register file: x1..x31 stored (x0 is hard-wired to zero),
// two combinational read ports and one synchronous write port.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : a read of the register being written this cycle returns the
//               write data (same-cycle WB-to-decode forwarding)
//   undefined : reads return the stored value; a write is visible next cycle
//
// Parameters:
//   XLEN       datapath width (32 only)
//   REG_RESET  reset value of x1..x31
// Ports:
//   clk        clock, writes on posedge
//   reset      asynchronous active-low reset
//   we         write enable (caller guarantees waddr != 0 when asserted)
//   waddr      write index
//   wdata      write data
//   raddr1/2   read indices
//   rdata1/2   read data, combinational
// -----------------------------------------------------------------------------
module writeback_regfile
   import wb_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] REG_RESET = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs [1:31];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= REG_RESET;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != 5'd0) rdata1 = regs[raddr1];
      if (raddr2 != 5'd0) rdata2 = regs[raddr2];
`ifdef WB_BYPASS_EN
      // Forward the value being written so decode sees it in the same cycle.
      if (we && (raddr1 != 5'd0) && (raddr1 == waddr)) rdata1 = wdata;
      if (we && (raddr2 != 5'd0) && (raddr2 == waddr)) rdata2 = wdata;
`endif
   end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final stage of the 3-stage RV32I pipeline. Selects the ALU result or the
// extracted load data, writes the register file, stalls fetch/execute while a
// load response is outstanding, and squashes the two wrong-path slots that
// follow a taken branch.
//
// Optional feature macro: WB_BYPASS_EN (same-cycle register bypass, handled in
// writeback_regfile).
//
// Parameters:
//   XLEN       datapath width (32 only)
//   REG_RESET  reset value of x1..x31
// Ports:
//   clk               clock
//   reset             asynchronous active-low reset
//   wb_result         ALU/jump/LUI result or store data
//   wb_alu_to_reg     instruction writes rd (loads included)
//   wb_mem_to_reg     instruction is a load
//   wb_mem_write      instruction is a store (never writes rd)
//   wb_dest_reg_sel   rd index
//   wb_read_address   load byte offset
//   wb_alu_operation  load funct3
//   wb_branch         instruction in WB is a taken branch/jump
//   dmem_rvalid       load data valid this cycle
//   dmem_rdata        raw aligned load word
//   reg_raddr1/2      decode read indices
//   reg_rdata1/2      decode read data, combinational
//   stall_read        hold fetch/execute (combinational)
//   stall_count       saturating count of stalled cycles
// -----------------------------------------------------------------------------
module writeback_stage
   import wb_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] REG_RESET = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] wb_result,
   input  logic            wb_alu_to_reg,
   input  logic            wb_mem_to_reg,
   input  logic            wb_mem_write,
   input  logic [4:0]      wb_dest_reg_sel,
   input  logic [1:0]      wb_read_address,
   input  logic [2:0]      wb_alu_operation,
   input  logic            wb_branch,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic [4:0]      reg_raddr1,
   input  logic [4:0]      reg_raddr2,
   output logic [XLEN-1:0] reg_rdata1,
   output logic [XLEN-1:0] reg_rdata2,
   output logic            stall_read,
   output logic [31:0]     stall_count
);

   wb_state_t       state;
   logic            sq1;
   logic            sq2;
   logic            slot_valid;
   logic            load_valid;
   logic            reg_we;
   logic [XLEN-1:0] reg_wdata;

   // A slot is wrong-path during the two unstalled cycles after a taken branch.
   assign slot_valid = !(sq1 || sq2);
   assign load_valid = slot_valid && wb_mem_to_reg && !wb_mem_write;

   // Gated by reset so the stall releases the moment reset is asserted, even
   // though upstream may still be presenting the pending load.
   assign stall_read = reset && !dmem_rvalid &&
                       (load_valid || (state == WB_WAIT));

   assign reg_we = wb_alu_to_reg && slot_valid && !wb_mem_write &&
                   (wb_dest_reg_sel != 5'd0) &&
                   (!wb_mem_to_reg || dmem_rvalid);

   assign reg_wdata = wb_mem_to_reg
                    ? load_extract(wb_alu_operation, wb_read_address, dmem_rdata)
                    : wb_result;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= WB_RUN;
      end else begin
         case (state)
            WB_RUN:  if (load_valid && !dmem_rvalid) state <= WB_WAIT;
            WB_WAIT: if (dmem_rvalid || !load_valid) state <= WB_RUN;
            default: state <= WB_RUN;
         endcase
      end
   end

   // Squash shift register only advances in unstalled cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sq1 <= 1'b0;
         sq2 <= 1'b0;
      end else if (!stall_read) begin
         sq1 <= wb_branch;
         sq2 <= sq1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= 32'h0000_0000;
      end else if (stall_read && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

   writeback_regfile #(
      .XLEN      (XLEN),
      .REG_RESET (REG_RESET)
   ) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (reg_we),
      .waddr  (wb_dest_reg_sel),
      .wdata  (reg_wdata),
      .raddr1 (reg_raddr1),
      .raddr2 (reg_raddr2),
      .rdata1 (reg_rdata1),
      .rdata2 (reg_rdata2)
   );

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Directed self-checking bench for writeback_stage. Inputs change just after
// the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;
   import wb_pkg::*;

   localparam logic [31:0] RR = 32'h0BAD_F00D;

   logic        clk;
   logic        reset;
   logic [31:0] wb_result;
   logic        wb_alu_to_reg;
   logic        wb_mem_to_reg;
   logic        wb_mem_write;
   logic [4:0]  wb_dest_reg_sel;
   logic [1:0]  wb_read_address;
   logic [2:0]  wb_alu_operation;
   logic        wb_branch;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [4:0]  reg_raddr1;
   logic [4:0]  reg_raddr2;
   logic [31:0] reg_rdata1;
   logic [31:0] reg_rdata2;
   logic        stall_read;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;

   writeback_stage #(
      .XLEN      (32),
      .REG_RESET (RR)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .wb_result        (wb_result),
      .wb_alu_to_reg    (wb_alu_to_reg),
      .wb_mem_to_reg    (wb_mem_to_reg),
      .wb_mem_write     (wb_mem_write),
      .wb_dest_reg_sel  (wb_dest_reg_sel),
      .wb_read_address  (wb_read_address),
      .wb_alu_operation (wb_alu_operation),
      .wb_branch        (wb_branch),
      .dmem_rvalid      (dmem_rvalid),
      .dmem_rdata       (dmem_rdata),
      .reg_raddr1       (reg_raddr1),
      .reg_raddr2       (reg_raddr2),
      .reg_rdata1       (reg_rdata1),
      .reg_rdata2       (reg_rdata2),
      .stall_read       (stall_read),
      .stall_count      (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      wb_result        = 32'h0;
      wb_alu_to_reg    = 1'b0;
      wb_mem_to_reg    = 1'b0;
      wb_mem_write     = 1'b0;
      wb_dest_reg_sel  = 5'd0;
      wb_read_address  = 2'd0;
      wb_alu_operation = 3'd0;
      wb_branch        = 1'b0;
      dmem_rvalid      = 1'b0;
      dmem_rdata       = 32'h0;
   endtask

   // Advance to the next falling edge (one rising edge passes in between).
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
      idle_inputs();
      wb_alu_to_reg   = 1'b1;
      wb_dest_reg_sel = rd;
      wb_result       = val;
   endtask

   task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
      reg_raddr2 = idx;
      #1;
      val = reg_rdata2;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      idle_inputs();
      reg_raddr1 = 5'd0;
      reg_raddr2 = 5'd0;
      reset = 1'b0;
      repeat (2) next_cycle();
      #1;
      checks++;
      if (stall_read !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %0b want 0", stall_read);
      end
      checks++;
      if (stall_count !== 32'h0) begin
         errors++; $display("FAIL reset_count: got %h want 0", stall_count);
      end
      reset = 1'b1;
      next_cycle();
      read_reg(5'd1, v);
      checks++;
      if (v !== RR) begin errors++; $display("FAIL reset_x1: got %h want %h", v, RR); end
      read_reg(5'd31, v);
      checks++;
      if (v !== RR) begin errors++; $display("FAIL reset_x31: got %h want %h", v, RR); end
      read_reg(5'd0, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_x0: got %h want 0", v); end
   endtask

   task automatic test_alu_write();
      logic [31:0] v;
      alu_write(5'd5, 32'hDEAD_BEEF);
      next_cycle();
      idle_inputs();
      read_reg(5'd5, v);
      checks++;
      if (v !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL alu_x5: got %h want deadbeef", v);
      end
      alu_write(5'd0, 32'hDEAD_BEEF);
      next_cycle();
      idle_inputs();
      read_reg(5'd0, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL alu_x0: got %h want 0", v); end
      // A store never writes rd, even with alu_to_reg set.
      alu_write(5'd6, 32'h5555_AAAA);
      wb_mem_write = 1'b1;
      next_cycle();
      idle_inputs();
      read_reg(5'd6, v);
      checks++;
      if (v !== RR) begin errors++; $display("FAIL store_nowrite: got %h want %h", v, RR); end
   endtask

   task automatic test_load_extract();
      logic [2:0]  f3  [7];
      logic [1:0]  off [7];
      logic [31:0] exp [7];
      logic [31:0] v;
      f3[0] = LB;     off[0] = 2'd0; exp[0] = 32'hFFFF_FFA5;
      f3[1] = LBU;    off[1] = 2'd1; exp[1] = 32'h0000_00F0;
      f3[2] = LH;     off[2] = 2'd2; exp[2] = 32'hFFFF_8070;
      f3[3] = LW;     off[3] = 2'd3; exp[3] = 32'h8070_F0A5;
      f3[4] = LHU;    off[4] = 2'd3; exp[4] = 32'h0000_8070;
      f3[5] = LH;     off[5] = 2'd1; exp[5] = 32'hFFFF_F0A5;
      f3[6] = 3'b011; off[6] = 2'd0; exp[6] = 32'h0000_0000;
      for (int i = 0; i < 7; i++) begin
         idle_inputs();
         wb_alu_to_reg    = 1'b1;
         wb_mem_to_reg    = 1'b1;
         wb_dest_reg_sel  = 5'(10 + i);
         wb_alu_operation = f3[i];
         wb_read_address  = off[i];
         wb_result        = 32'h1111_1111;
         dmem_rvalid      = 1'b1;
         dmem_rdata       = 32'h8070_F0A5;
         #1;
         checks++;
         if (stall_read !== 1'b0) begin
            errors++; $display("FAIL load_nostall_%0d: got %0b want 0", i, stall_read);
         end
         next_cycle();
         idle_inputs();
         read_reg(5'(10 + i), v);
         checks++;
         if (v !== exp[i]) begin
            errors++; $display("FAIL load_extract_%0d: got %h want %h", i, v, exp[i]);
         end
      end
      checks++;
      if (stall_count !== 32'h0) begin
         errors++; $display("FAIL load_count: got %0d want 0", stall_count);
      end
   endtask

   task automatic test_slow_load();
      logic [31:0] v;
      idle_inputs();
      wb_alu_to_reg    = 1'b1;
      wb_mem_to_reg    = 1'b1;
      wb_dest_reg_sel  = 5'd20;
      wb_alu_operation = LW;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (stall_read !== 1'b1) begin
            errors++; $display("FAIL slow_stall_c%0d: got %0b want 1", c, stall_read);
         end
         next_cycle();
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1122_3344;
      #1;
      checks++;
      if (stall_read !== 1'b0) begin
         errors++; $display("FAIL slow_release: got %0b want 0", stall_read);
      end
      next_cycle();
      idle_inputs();
      read_reg(5'd20, v);
      checks++;
      if (v !== 32'h1122_3344) begin
         errors++; $display("FAIL slow_data: got %h want 11223344", v);
      end
      checks++;
      if (stall_count !== 32'd3) begin
         errors++; $display("FAIL slow_count: got %0d want 3", stall_count);
      end
   endtask

   task automatic test_branch_squash();
      logic [31:0] v;
      idle_inputs();
      wb_branch = 1'b1;                 // T
      next_cycle();
      alu_write(5'd7, 32'h0000_0077);   // T+1, squashed
      next_cycle();
      idle_inputs();                    // T+2, squashed load must not stall
      wb_alu_to_reg    = 1'b1;
      wb_mem_to_reg    = 1'b1;
      wb_dest_reg_sel  = 5'd7;
      wb_alu_operation = LW;
      #1;
      checks++;
      if (stall_read !== 1'b0) begin
         errors++; $display("FAIL squash_nostall: got %0b want 0", stall_read);
      end
      next_cycle();
      alu_write(5'd8, 32'h0000_0088);   // T+3, valid
      next_cycle();
      idle_inputs();
      read_reg(5'd7, v);
      checks++;
      if (v !== RR) begin errors++; $display("FAIL squash_x7: got %h want %h", v, RR); end
      read_reg(5'd8, v);
      checks++;
      if (v !== 32'h0000_0088) begin
         errors++; $display("FAIL squash_x8: got %h want 00000088", v);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] v;
      logic [31:0] exp;
`ifdef WB_BYPASS_EN
      exp = 32'h0000_1234;
`else
      exp = RR;
`endif
      alu_write(5'd9, 32'h0000_1234);
      reg_raddr1 = 5'd9;
      #1;
      checks++;
      if (reg_rdata1 !== exp) begin
         errors++; $display("FAIL bypass_same_cycle: got %h want %h", reg_rdata1, exp);
      end
      next_cycle();
      idle_inputs();
      #1;
      checks++;
      if (reg_rdata1 !== 32'h0000_1234) begin
         errors++; $display("FAIL bypass_next_cycle: got %h want 00001234", reg_rdata1);
      end
      reg_raddr1 = 5'd0;
      read_reg(5'd9, v);
      checks++;
      if (v !== 32'h0000_1234) begin
         errors++; $display("FAIL bypass_port2: got %h want 00001234", v);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] v;
      idle_inputs();
      wb_alu_to_reg    = 1'b1;
      wb_mem_to_reg    = 1'b1;
      wb_dest_reg_sel  = 5'd13;
      wb_alu_operation = LW;
      next_cycle();                     // now in WB_WAIT
      #1;
      checks++;
      if (stall_read !== 1'b1) begin
         errors++; $display("FAIL wait_stall: got %0b want 1", stall_read);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (stall_read !== 1'b0) begin
         errors++; $display("FAIL rst_wait_stall: got %0b want 0", stall_read);
      end
      checks++;
      if (stall_count !== 32'h0) begin
         errors++; $display("FAIL rst_wait_count: got %0d want 0", stall_count);
      end
      read_reg(5'd5, v);
      checks++;
      if (v !== RR) begin errors++; $display("FAIL rst_wait_x5: got %h want %h", v, RR); end
      next_cycle();
      idle_inputs();
      reset = 1'b1;
      next_cycle();
      dmem_rvalid = 1'b1;               // late response, nothing in WB
      dmem_rdata  = 32'hCAFE_F00D;
      next_cycle();
      idle_inputs();
      read_reg(5'd13, v);
      checks++;
      if (v !== RR) begin errors++; $display("FAIL late_rvalid_x13: got %h want %h", v, RR); end
      checks++;
      if (stall_read !== 1'b0) begin
         errors++; $display("FAIL late_rvalid_stall: got %0b want 0", stall_read);
      end
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      reg_raddr1 = 5'd0;
      reg_raddr2 = 5'd0;
      @(negedge clk);
      test_reset();
      test_alu_write();
      test_load_extract();
      test_slow_load();
      test_branch_squash();
      test_bypass();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the 3-stage RV32I pipeline. Consumes the `wb_*` bundle registered by the execute stage and selects ALU result or returned load data. Aligns and sign-extends loads, then writes the 32x32 register file. Owns `stall_read`: it freezes fetch/execute while a load's data-memory response is outstanding. Also squashes the two wrong-path slots that follow a taken branch.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `REG_RESET`, 32'h0000_0000, reset value of x1..x31.

Ports:
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `wb_result`  in  32  ALU/jump/LUI result, or store data.
- `wb_alu_to_reg`  in  1  instruction writes rd (includes loads).
- `wb_mem_to_reg`  in  1  instruction is a load.
- `wb_mem_write`  in  1  store; never writes rd.
- `wb_dest_reg_sel`  in  5  rd index.
- `wb_read_address`  in  2  load byte offset.
- `wb_alu_operation`  in  3  load funct3.
- `wb_branch`  in  1  instruction in WB was a taken branch/jump.
- `dmem_rvalid`  in  1  load data valid this cycle.
- `dmem_rdata`  in  32  raw aligned load word.
- `reg_raddr1`, `reg_raddr2`  in  5 each  decode read indices.
- `reg_rdata1`, `reg_rdata2`  out  32 each  read data, combinational.
- `stall_read`  out  1  hold fetch/execute.
- `stall_count`  out  32  saturating count of cycles with `stall_read` high.

## Operation
- The FSM has two states, `WB_RUN` and `WB_WAIT`. Reset state is `WB_RUN`.
- `WB_RUN`:
  - A valid load with `dmem_rvalid`=0 moves the FSM to `WB_WAIT`. `stall_read` goes high combinationally in that same cycle.
  - A load with `dmem_rvalid`=1 retires in the same cycle.
- `WB_WAIT`:
  - `stall_read`=1. The `wb_*` inputs are held stable by upstream.
  - On `dmem_rvalid`=1: data is written, `stall_read` drops combinationally in that cycle, and the next state is `WB_RUN`.
- Valid means not squashed.
  - Two registers, `sq1` and `sq2`, form the squash state. Each advances only when `stall_read`=0: `sq1`<=`wb_branch`, `sq2`<=`sq1`.
  - The slot in WB is squashed when `sq1|sq2`.
  - A squashed slot never writes, never stalls, and ignores `dmem_rvalid`.
- Write enable is `wb_alu_to_reg` & valid & (`wb_dest_reg_sel`!=0) & (!`wb_mem_to_reg` | `dmem_rvalid`).
  - `wb_mem_write` forces write enable to 0.
- Load extraction:
  - LB (000) and LBU (100) take the byte at `wb_read_address`.
  - LH (001) and LHU (101) take the half selected by `wb_read_address[1]`; bit 0 is ignored.
  - LW (010) takes the full word and ignores the offset.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - The reserved encodings 011, 110 and 111 write 32'h0.
- Register reads:
  - x0 always reads 0 and is never written.
  - All other registers return their stored value, or the bypass value when it is enabled (see Configuration).
- `stall_count` increments on every cycle with `stall_read`=1 and saturates at 32'hFFFF_FFFF.
- Reset values:
  - `stall_read`=0, `stall_count`=0, `sq1`=`sq2`=0.
  - x1..x31 are set to `REG_RESET`.
- Reset asserted in `WB_WAIT` returns the FSM to `WB_RUN` immediately. The pending load is discarded.
- A `dmem_rvalid` pulse while no load is in WB is ignored.

## Timing
- ALU result: written at the posedge ending its WB cycle. Readable by decode from the following cycle, or in the same cycle with bypass enabled.
- Load with single-cycle memory: zero added stall.
- Load with N-cycle response: `stall_read` is high for exactly N-1 cycles. Write occurs at the posedge of the `dmem_rvalid` cycle.
- Taken branch in WB at cycle T:
  - Slots in WB at T+1 and T+2 are squashed, counted in unstalled cycles.
  - Slot squash cannot overlap a stall, because squashed slots never stall.

## Configuration
- The feature is controlled by macro `WB_BYPASS_EN`.
- With the macro defined:
  - `reg_rdataN` returns the write data when write enable=1 and `reg_raddrN`==`wb_dest_reg_sel`!=0 in the same cycle.
  - This removes the WB-to-decode hazard.
- Without the macro:
  - Reads return the stored value only.
  - The new value is visible the cycle after the write.

## Structure
- Package `wb_pkg`:
  - Load funct3 constants `LB`, `LH`, `LW`, `LBU`, `LHU`.
  - `wb_state_t` enum (`WB_RUN`, `WB_WAIT`).
  - Load-extract function.
- Sub-module `writeback_regfile`:
  - 31x32 storage, two async read ports, one sync write port.
  - Optional bypass, selected by `WB_BYPASS_EN`.
  - Reset to `REG_RESET`.
- The FSM, squash registers, extract mux and counter stay in `writeback_stage`.

## Test plan
- ALU write and x0 protection:
  - `wb_alu_to_reg`=1, rd=5, result=32'hDEAD_BEEF; the next cycle reads x5 = 32'hDEAD_BEEF.
  - The same stimulus with rd=0 reads x0 = 0.
- Load extract:
  - `dmem_rdata`=32'h8070_F0A5, `dmem_rvalid`=1.
  - LB at offset 0 writes 32'hFFFF_FFA5. LBU at offset 1 writes 32'h0000_00F0. LH at offset 2 writes 32'hFFFF_8070. LW writes 32'h8070_F0A5.
- Slow load:
  - `dmem_rvalid` rises 3 cycles after the load enters WB.
  - `stall_read` is high for 3 cycles, then drops in the `dmem_rvalid` cycle. rd is written and `stall_count`=3.
- Branch squash:
  - `wb_branch`=1 at T, with ALU writes to x7 at T+1 and T+2 and to x8 at T+3.
  - x7 is unchanged and x8 is written.
- Bypass:
  - Write x9=32'h1234 while `reg_raddr1`=9 in the same cycle.
  - `reg_rdata1`=32'h1234 with `WB_BYPASS_EN` defined; the old value without it.
- Reset mid-wait:
  - Assert `reset`=0 during `WB_WAIT`.
  - `stall_read` drops immediately and all registers hold `REG_RESET`. After release, a late `dmem_rvalid` causes no write.
